// File: rtl/led_trail_pwm.sv
// Comet-trail PWM stage: each LED is held at full brightness while selected, then decays to off.
// Define LED_TRAIL_GAMMA_EN to apply a squared (gamma) duty curve; the default build uses linear duty.
module led_trail_pwm #(
  parameter int N_LED      = 4,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 250000,
  parameter int DECAY_STEP = 16
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [N_LED-1:0]          led_in,
  output logic [N_LED-1:0]          led_out,
  output logic [N_LED*PWM_BITS-1:0] level_o
);

  localparam int CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DECAY_DIV - 1);

  typedef enum logic [1:0] {OFF, HOLD, FADE} state_t;

  logic [N_LED-1:0]    sync1_q, sync1_d;
  logic [N_LED-1:0]    led_s_q, led_s_d;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  state_t              state_q  [N_LED];
  state_t              state_d  [N_LED];
  logic [PWM_BITS-1:0] level_q  [N_LED];
  logic [PWM_BITS-1:0] level_d  [N_LED];
  logic [PWM_BITS-1:0] shadow_q [N_LED];
  logic [PWM_BITS-1:0] shadow_d [N_LED];
  logic [PWM_BITS-1:0] duty     [N_LED];
  logic [N_LED-1:0]    led_out_q, led_out_d;
`ifdef LED_TRAIL_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq [N_LED];
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q   <= '0;
      led_s_q   <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= '0;
      for (int i = 0; i < N_LED; i++) begin
        state_q[i]  <= OFF;
        level_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      led_s_q   <= led_s_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
      for (int i = 0; i < N_LED; i++) begin
        state_q[i]  <= state_d[i];
        level_q[i]  <= level_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign tick = (presc_q == DIV_LAST);

  always_comb begin
    sync1_d   = led_in;
    led_s_d   = sync1_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  // A fresh set from the sequencer always wins over a decay tick in the same cycle.
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
      case (state_q[i])
        OFF: begin
          level_d[i] = '0;
          if (led_s_q[i]) begin
            state_d[i] = HOLD;
            level_d[i] = MAX;
          end
        end
        HOLD: begin
          level_d[i] = MAX;
          if (!led_s_q[i]) state_d[i] = FADE;
        end
        FADE: begin
          if (led_s_q[i]) begin
            state_d[i] = HOLD;
            level_d[i] = MAX;
          end else if (tick) begin
            if (level_q[i] > STEP) begin
              level_d[i] = level_q[i] - STEP;
            end else begin
              level_d[i] = '0;
              state_d[i] = OFF;
            end
          end
        end
        default: begin
          state_d[i] = OFF;
          level_d[i] = '0;
        end
      endcase
    end
  end

  // Shadow only updates at the PWM period boundary so a duty change never splits a period.
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      shadow_d[i] = (pwm_cnt_q == MAX) ? level_q[i] : shadow_q[i];
`ifdef LED_TRAIL_GAMMA_EN
      duty_sq[i] = {{PWM_BITS{1'b0}}, shadow_q[i]} * {{PWM_BITS{1'b0}}, shadow_q[i]};
      duty[i]    = duty_sq[i][2*PWM_BITS-1:PWM_BITS];
`else
      duty[i]    = shadow_q[i];
`endif
      led_out_d[i] = (shadow_q[i] == MAX) | (pwm_cnt_q < duty[i]);
    end
  end

  assign led_out = led_out_q;

  for (genvar g = 0; g < N_LED; g++) begin : g_level
    assign level_o[g*PWM_BITS +: PWM_BITS] = level_q[g];
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: stimulus queues expectations per cycle, a negedge monitor checks them.
module tb_led_trail_pwm;

  localparam int K_OUT  = 0;
  localparam int K_LVL  = 1;
  localparam int K_LVL2 = 2;
  localparam int K_HI   = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  led_in, led_in2;
  logic [3:0]  led_out, led_out2;
  logic [31:0] level, level2;

  typedef struct {
    int cyc;
    int kind;
    int exp;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         r0 = 0;
  int         last_cyc = 0;
  bit [255:0] hist2 = '0;

  always #5 clk = ~clk;

  led_trail_pwm #(.N_LED(4), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(64)) u_dut (
    .clk(clk), .nrst(nrst), .led_in(led_in), .led_out(led_out), .level_o(level)
  );

  // Second instance with a slow decay so a mid level can be held across a full PWM period.
  led_trail_pwm #(.N_LED(4), .PWM_BITS(8), .DECAY_DIV(1024), .DECAY_STEP(127)) u_dut2 (
    .clk(clk), .nrst(nrst), .led_in(led_in2), .led_out(led_out2), .level_o(level2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input int kind, input int e);
    exp_t x;
    int idx;
    x.cyc  = c;
    x.kind = kind;
    x.exp  = e;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, x);
    if (c > last_cyc) last_cyc = c;
  endtask

  function automatic int next_mult(input int from, input int period);
    int m;
    m = (from - r0 + period - 1) / period;
    return r0 + m * period;
  endfunction

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int    act;
    string nm;
    hist2 = {hist2[254:0], led_out2[0]};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      case (sb[0].kind)
        K_OUT:   begin act = int'(led_out); nm = "led_out";  end
        K_LVL:   begin act = int'(level);   nm = "level_o";  end
        K_LVL2:  begin act = int'(level2);  nm = "level2_o"; end
        default: begin act = $countones(hist2); nm = "duty_count"; end
      endcase
      total++;
      if (act != sb[0].exp) begin
        bad++;
        $display("[TB] FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, sb[0].exp);
      end
      void'(sb.pop_front());
    end
  end

  initial begin
    int k, t, t3, e, e2, big_t;
    nrst    = 1'b0;
    led_in  = 4'b1111;
    led_in2 = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      expect_at(c, K_OUT, 0);
      expect_at(c, K_LVL, 0);
      expect_at(c, K_LVL2, 0);
    end

    // release reset with pattern cleared; nothing may light for 1024 clocks
    go_to(10);
    led_in  = 4'b0000;
    led_in2 = 4'b0000;
    nrst    = 1'b1;
    r0      = cyc;
    for (int c = r0 + 1; c <= r0 + 1024; c++) expect_at(c, K_OUT, 0);

    // set channel 0: full level on 3rd clock, fully lit after next period boundary
    go_to(r0 + 1040);
    k = cyc;
    expect_at(k + 2, K_LVL, 0);
    expect_at(k + 3, K_LVL, 255);
    e = next_mult(k + 4, 256);
    expect_at(e, K_OUT, 0);
    for (int j = 1; j <= 300; j++) expect_at(e + j, K_OUT, 1);
    led_in = 4'b0001;
    go_to(e + 300);

    // release: saturating fade 255,191,127,63,0 then dark
    k = cyc;
    led_in = 4'b0000;
    t = next_mult(k + 4, 4);
    expect_at(t - 1,  K_LVL, 255);
    expect_at(t,      K_LVL, 191);
    expect_at(t + 4,  K_LVL, 127);
    expect_at(t + 8,  K_LVL, 63);
    expect_at(t + 12, K_LVL, 0);
    expect_at(t + 40, K_LVL, 0);
    e2 = next_mult(t + 13, 256);
    expect_at(e2 + 1,  K_OUT, 0);
    expect_at(e2 + 50, K_OUT, 0);
    go_to(e2 + 51);

    // re-trigger at level 127 with the set landing on the same cycle as a tick
    k = cyc;
    led_in = 4'b0001;
    expect_at(k + 3, K_LVL, 255);
    go_to(k + 6);
    led_in = 4'b0000;
    t = next_mult(k + 10, 4);
    expect_at(t,      K_LVL, 191);
    expect_at(t + 4,  K_LVL, 127);
    expect_at(t + 7,  K_LVL, 127);
    expect_at(t + 8,  K_LVL, 255);
    expect_at(t + 12, K_LVL, 255);
    expect_at(t + 30, K_LVL, 255);
    go_to(t + 5);
    led_in = 4'b0001;
    go_to(t + 31);
    led_in = 4'b0000;
    k = cyc;
    t3 = next_mult(k + 4, 4);
    expect_at(t3 - 1, K_LVL, 255);
    expect_at(t3,     K_LVL, 191);

    // short reset pulse between clock edges mid-fade must clear everything at once
    expect_at(t3 + 1, K_LVL, 0);
    expect_at(t3 + 1, K_OUT, 0);
    expect_at(t3 + 1, K_LVL2, 0);
    go_to(t3 + 1);
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    r0 = cyc;
    expect_at(r0 + 5,  K_LVL, 0);
    expect_at(r0 + 20, K_LVL, 0);

    // second instance: park at level 128 for a full PWM period and count lit clocks
    go_to(r0 + 1);
    led_in2 = 4'b0001;
    expect_at(r0 + 4, K_LVL2, 255);
    go_to(r0 + 10);
    led_in2 = 4'b0000;
    big_t = next_mult(r0 + 14, 1024);
    expect_at(big_t - 1, K_LVL2, 255);
    expect_at(big_t,     K_LVL2, 128);
    e = next_mult(big_t + 1, 256);
`ifdef LED_TRAIL_GAMMA_EN
    expect_at(e + 256, K_HI, 64);
`else
    expect_at(e + 256, K_HI, 128);
`endif

    // channel 0 restarts cleanly from OFF after the pulse
    go_to(r0 + 30);
    led_in = 4'b0001;
    expect_at(r0 + 32, K_LVL, 0);
    expect_at(r0 + 33, K_LVL, 255);

    go_to(last_cyc + 2);
    if (sb.size() != 0) begin
      $display("[TB] FAIL pending_checks left=%0d required=0", sb.size());
      total += sb.size();
      bad   += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
